// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N-channel programmable tick generator with shadowed, glitch-free period updates.
// Optional one-shot mode is built when the macro TICKGEN_ONESHOT_EN is defined.
module tick_gen_multi #(
   parameter int  CLK_FREQ = 100_000_000,
   parameter int  DEF_FREQ = 1000,
   parameter int  N_CH     = 4,
   parameter int  CNT_W    = 32,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_100Mhz,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic             sync_clr,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic             cfg_oneshot,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  busy
);

`ifdef TICKGEN_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   localparam logic [CNT_W-1:0] P0 = CNT_W'(CLK_FREQ / DEF_FREQ);

   logic [CNT_W-1:0] cnt_q    [N_CH];
   logic [CNT_W-1:0] cnt_d    [N_CH];
   logic [CNT_W-1:0] period_q [N_CH];
   logic [CNT_W-1:0] period_d [N_CH];
   logic [CNT_W-1:0] shadow_q [N_CH];
   logic [CNT_W-1:0] shadow_d [N_CH];
   logic [N_CH-1:0]  pending_q, pending_d;
   logic [N_CH-1:0]  oneshot_q, oneshot_d;
   logic [N_CH-1:0]  shos_q, shos_d;
   logic [N_CH-1:0]  stopped_q, stopped_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic [N_CH-1:0]  busy_q, busy_d;
   logic             accept;
   logic             hit, last, applied;

   // Out-of-range channel numbers match no channel, so they are always ready and dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if (cfg_ch == CH_W'(c)) cfg_ready = ~pending_q[c];
      end
   end

   assign accept = cfg_valid & cfg_ready;

   always_comb begin
      cnt_d     = cnt_q;
      period_d  = period_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      oneshot_d = oneshot_q;
      shos_d    = shos_q;
      stopped_d = stopped_q;
      tick_d    = '0;
      busy_d    = '0;
      hit       = 1'b0;
      last      = 1'b0;
      applied   = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         hit  = accept && (cfg_ch == CH_W'(c));
         last = (period_q[c] <= CNT_W'(1)) || (cnt_q[c] == period_q[c] - CNT_W'(1));
         if (sync_clr || !en[c] || stopped_q[c]) begin
            // Channel not counting: shadow and fresh writes land in the live period immediately.
            cnt_d[c] = '0;
            applied  = pending_q[c] | hit;
            if (pending_q[c]) begin
               period_d[c]  = shadow_q[c];
               oneshot_d[c] = shos_q[c];
            end
            if (hit) begin
               period_d[c]  = cfg_period;
               oneshot_d[c] = ONESHOT & cfg_oneshot;
            end
            pending_d[c] = 1'b0;
            stopped_d[c] = stopped_q[c] & en[c] & ~sync_clr & ~applied;
         end else begin
            if (last) begin
               cnt_d[c]  = '0;
               tick_d[c] = 1'b1;
               if (pending_q[c]) begin
                  period_d[c]  = shadow_q[c];
                  oneshot_d[c] = shos_q[c];
               end
               pending_d[c] = 1'b0;
               stopped_d[c] = ONESHOT & oneshot_q[c] & ~pending_q[c];
            end else begin
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
            // pending_q is clear here (write was ready), so it simply waits for the next terminal count.
            if (hit) begin
               shadow_d[c]  = cfg_period;
               shos_d[c]    = ONESHOT & cfg_oneshot;
               pending_d[c] = 1'b1;
            end
         end
         busy_d[c] = en[c] & ~stopped_d[c];
      end
   end

   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c]    <= '0;
            period_q[c] <= P0;
            shadow_q[c] <= P0;
         end
         pending_q <= '0;
         oneshot_q <= '0;
         shos_q    <= '0;
         stopped_q <= '0;
         tick_q    <= '0;
         busy_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         oneshot_q <= oneshot_d;
         shos_q    <= shos_d;
         stopped_q <= stopped_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
      end
   end

   assign tick = tick_q;
   assign busy = busy_q;

endmodule
